// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage RISC-V pipeline: EX operand forwarding, load-use and
// memory wait-state stalls, a MUL/DIV destination scoreboard and a multi-cycle redirect flush.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int MC_DEPTH     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reg_write_me,
  input  logic                       reg_write_wb,
  input  logic                       mem_read_me,
  input  logic                       mem_ready,
  input  logic [REG_ADDR_W-1:0]      rd_me,
  input  logic [REG_ADDR_W-1:0]      rd_wb,
  input  logic [REG_ADDR_W-1:0]      rs1_ex,
  input  logic [REG_ADDR_W-1:0]      rs2_ex,
  input  logic [REG_ADDR_W-1:0]      rs1_de,
  input  logic [REG_ADDR_W-1:0]      rs2_de,
  input  logic [REG_ADDR_W-1:0]      rd_de,
  input  logic                       reg_write_de,
  input  logic                       mc_issue_ex,
  input  logic [REG_ADDR_W-1:0]      rd_ex,
  input  logic                       mc_done,
  input  logic [REG_ADDR_W-1:0]      mc_rd,
  input  logic                       pc_r,
  output logic [1:0]                 hu_rs1,
  output logic [1:0]                 hu_rs2,
  output logic                       stall_fe,
  output logic                       stall_de,
  output logic                       stall_ex,
  output logic                       stall_me,
  output logic                       bubble_me,
  output logic                       flush_de,
  output logic                       flush_ex,
  output logic [2**REG_ADDR_W-1:0]   busy_mask
);

  localparam int NREG = 2**REG_ADDR_W;
  localparam int MC_W = $clog2(MC_DEPTH + 1);
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] HU_SRC_REG = 2'd0;
  localparam logic [1:0] HU_SRC_MEM = 2'd1;
  localparam logic [1:0] HU_SRC_WB  = 2'd2;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_REDIRECT,
    CAUSE_MEM_WAIT,
    CAUSE_LOAD_USE,
    CAUSE_SB_HAZARD,
    CAUSE_MC_FULL
  } cause_e;

  logic [NREG-1:0] busy_q, busy_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;

  cause_e cause;
  logic   mem_wait, load_use, sb_hazard, mc_full;
  logic   mc_inc, mc_dec;

  // The ME-stage producer is younger than WB, so it must win when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  we_me,
    input logic [REG_ADDR_W-1:0] dst_me,
    input logic                  we_wb,
    input logic [REG_ADDR_W-1:0] dst_wb
  );
    if (we_me && dst_me != '0 && dst_me == rs)      return HU_SRC_MEM;
    else if (we_wb && dst_wb != '0 && dst_wb == rs) return HU_SRC_WB;
    else                                            return HU_SRC_REG;
  endfunction

  assign hu_rs1 = fwd_sel(rs1_ex, reg_write_me, rd_me, reg_write_wb, rd_wb);
  assign hu_rs2 = fwd_sel(rs2_ex, reg_write_me, rd_me, reg_write_wb, rd_wb);

  assign mem_wait  = mem_read_me & ~mem_ready;
  assign load_use  = mem_read_me & mem_ready & (rd_me != '0) &
                     ((rd_me == rs1_ex) | (rd_me == rs2_ex));
  assign sb_hazard = busy_q[rs1_de] | busy_q[rs2_de] | (reg_write_de & busy_q[rd_de]);
  assign mc_full   = mc_issue_ex & (mc_cnt_q == MC_W'(MC_DEPTH)) & ~mc_done;

  always_comb begin
    if (pc_r)           cause = CAUSE_REDIRECT;
    else if (mem_wait)  cause = CAUSE_MEM_WAIT;
    else if (load_use)  cause = CAUSE_LOAD_USE;
    else if (sb_hazard) cause = CAUSE_SB_HAZARD;
    else if (mc_full)   cause = CAUSE_MC_FULL;
    else                cause = CAUSE_NONE;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    stall_fe  = 1'b0;
    stall_de  = 1'b0;
    stall_ex  = 1'b0;
    stall_me  = 1'b0;
    bubble_me = 1'b0;
    flush_ex  = 1'b0;
    unique case (cause)
      CAUSE_REDIRECT:  flush_ex = 1'b1;
      CAUSE_MEM_WAIT:  begin
        stall_fe = 1'b1; stall_de = 1'b1; stall_ex = 1'b1; stall_me = 1'b1;
      end
      CAUSE_LOAD_USE,
      CAUSE_MC_FULL:   begin
        stall_fe = 1'b1; stall_de = 1'b1; stall_ex = 1'b1; bubble_me = 1'b1;
      end
      CAUSE_SB_HAZARD: begin
        stall_fe = 1'b1; stall_de = 1'b1; flush_ex = 1'b1;
      end
      default: ;
    endcase
    flush_de = pc_r | (fl_cnt_q != '0);
  end

  // An issue is accepted whenever EX advances; a completion with nothing outstanding is dropped.
  assign mc_inc = ~stall_ex & mc_issue_ex;
  assign mc_dec = mc_done & (mc_cnt_q != '0);

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (mc_inc && !mc_dec && mc_cnt_q != MC_W'(MC_DEPTH)) mc_cnt_d = mc_cnt_q + MC_W'(1);
    else if (mc_dec && !mc_inc)                           mc_cnt_d = mc_cnt_q - MC_W'(1);
  end

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (mc_done)                 busy_d[mc_rd] = 1'b0;
    if (mc_inc && rd_ex != '0)   busy_d[rd_ex] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    fl_cnt_d = fl_cnt_q;
    if (pc_r)                  fl_cnt_d = FL_W'(FLUSH_CYCLES - 1);
    else if (fl_cnt_q != '0)   fl_cnt_d = fl_cnt_q - FL_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      busy_q   <= busy_d;
      mc_cnt_q <= mc_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic,
// all compared against a queue/array reference model of the hazard rules.
module tb_hazard_scoreboard;

  localparam int RAW          = 5;
  localparam int NREG         = 2**RAW;
  localparam int MC_DEPTH     = 2;
  localparam int FLUSH_CYCLES = 2;

  localparam logic [1:0] SRC_REG = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_WB  = 2'd2;

  logic           clk = 1'b0;
  logic           rst;
  logic           reg_write_me, reg_write_wb, mem_read_me, mem_ready;
  logic [RAW-1:0] rd_me, rd_wb, rs1_ex, rs2_ex, rs1_de, rs2_de, rd_de, rd_ex, mc_rd;
  logic           reg_write_de, mc_issue_ex, mc_done, pc_r;
  logic [1:0]     hu_rs1, hu_rs2;
  logic           stall_fe, stall_de, stall_ex, stall_me, bubble_me, flush_de, flush_ex;
  logic [NREG-1:0] busy_mask;

  hazard_scoreboard #(
    .REG_ADDR_W(RAW), .MC_DEPTH(MC_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .reg_write_me(reg_write_me), .reg_write_wb(reg_write_wb),
    .mem_read_me(mem_read_me), .mem_ready(mem_ready),
    .rd_me(rd_me), .rd_wb(rd_wb), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de), .reg_write_de(reg_write_de),
    .mc_issue_ex(mc_issue_ex), .rd_ex(rd_ex), .mc_done(mc_done), .mc_rd(mc_rd),
    .pc_r(pc_r),
    .hu_rs1(hu_rs1), .hu_rs2(hu_rs2),
    .stall_fe(stall_fe), .stall_de(stall_de), .stall_ex(stall_ex), .stall_me(stall_me),
    .bubble_me(bubble_me), .flush_de(flush_de), .flush_ex(flush_ex),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: per-register busy flags, FIFO of outstanding op destinations, flush cycles left.
  bit m_busy[NREG];
  int m_q[$];
  int m_fl;

  logic [1:0]      exp_rs1, exp_rs2;
  logic [4:0]      exp_stall;   // {fe, de, ex, me, bubble_me}
  logic [1:0]      exp_flush;   // {de, ex}
  logic [NREG-1:0] exp_busy;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_q.delete();
    m_fl = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RAW-1:0] rs);
    if (reg_write_me && rd_me != 0 && rd_me == rs) return SRC_MEM;
    if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return SRC_WB;
    return SRC_REG;
  endfunction

  function automatic void predict();
    bit wait_mem, lu, sb, full;
    exp_rs1   = ref_fwd(rs1_ex);
    exp_rs2   = ref_fwd(rs2_ex);
    wait_mem  = mem_read_me && !mem_ready;
    lu        = mem_read_me && mem_ready && rd_me != 0 && (rd_me == rs1_ex || rd_me == rs2_ex);
    sb        = m_busy[rs1_de] || m_busy[rs2_de] || (reg_write_de && m_busy[rd_de]);
    full      = mc_issue_ex && m_q.size() == MC_DEPTH && !mc_done;
    exp_stall = 5'b00000;
    exp_flush = 2'b00;
    if (pc_r)          exp_flush = 2'b11;
    else if (wait_mem) exp_stall = 5'b11110;
    else if (lu)       exp_stall = 5'b11101;
    else if (sb)       begin exp_stall = 5'b11000; exp_flush = 2'b01; end
    else if (full)     exp_stall = 5'b11101;
    if (m_fl > 0) exp_flush[1] = 1'b1;
    for (int i = 0; i < NREG; i++) exp_busy[i] = m_busy[i];
  endfunction

  function automatic void model_clock();
    bit accept;
    accept = !exp_stall[2] && mc_issue_ex;
    if (mc_done) begin
      m_busy[mc_rd] = 1'b0;
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    if (accept) begin
      if (rd_ex != 0) m_busy[rd_ex] = 1'b1;
      if (m_q.size() < MC_DEPTH) m_q.push_back(int'(rd_ex));
    end
    if (pc_r)          m_fl = FLUSH_CYCLES - 1;
    else if (m_fl > 0) m_fl--;
  endfunction

  task automatic settle();
    #1;
    predict();
    check("hu_rs1", 64'(hu_rs1), 64'(exp_rs1));
    check("hu_rs2", 64'(hu_rs2), 64'(exp_rs2));
    check("stalls", 64'({stall_fe, stall_de, stall_ex, stall_me, bubble_me}), 64'(exp_stall));
    check("flush",  64'({flush_de, flush_ex}), 64'(exp_flush));
    check("busy",   64'(busy_mask), 64'(exp_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    reg_write_me = 0; reg_write_wb = 0; mem_read_me = 0; mem_ready = 1;
    rd_me = 0; rd_wb = 0; rs1_ex = 0; rs2_ex = 0; rs1_de = 0; rs2_de = 0; rd_de = 0;
    reg_write_de = 0; mc_issue_ex = 0; rd_ex = 0; mc_done = 0; mc_rd = 0; pc_r = 0;
  endtask

  task automatic randomize_inputs();
    reg_write_me = 1'($urandom_range(0, 1));
    rd_me        = RAW'($urandom_range(0, 7));
    mem_read_me  = ($urandom_range(0, 3) == 0);
    if (mem_read_me) reg_write_me = 1'b1;
    mem_ready    = ($urandom_range(0, 3) != 0);
    reg_write_wb = 1'($urandom_range(0, 1));
    rd_wb        = RAW'($urandom_range(0, 7));
    rs1_ex       = RAW'($urandom_range(0, 7));
    rs2_ex       = RAW'($urandom_range(0, 7));
    rs1_de       = RAW'($urandom_range(0, 7));
    rs2_de       = RAW'($urandom_range(0, 7));
    rd_de        = RAW'($urandom_range(0, 7));
    reg_write_de = 1'($urandom_range(0, 1));
    pc_r         = ($urandom_range(0, 15) == 0);
    mc_issue_ex  = !pc_r && ($urandom_range(0, 3) == 0);
    rd_ex        = RAW'($urandom_range(0, 7));
    mc_done      = (m_q.size() > 0) && ($urandom_range(0, 3) == 0);
    mc_rd        = mc_done ? RAW'(m_q[0]) : RAW'($urandom_range(0, 7));
  endtask

  initial begin
    int stall_me_cycles;
    bit fl_seq_pc[5]  = '{1, 0, 1, 0, 0};
    bit fl_seq_exp[5] = '{1, 1, 1, 1, 0};

    // Reset state
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_busy", 64'(busy_mask), 64'd0);
    check("reset_outs", 64'({hu_rs1, hu_rs2, stall_fe, stall_de, stall_ex, stall_me,
                             bubble_me, flush_de, flush_ex}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    settle(); tick();

    // Forwarding: MEM beats WB; rd 0 never forwards
    reg_write_me = 1; rd_me = 5; reg_write_wb = 1; rd_wb = 5; rs1_ex = 5;
    settle();
    check("fwd_mem_prio", 64'(hu_rs1), 64'(SRC_MEM));
    tick();
    rd_me = 0; rd_wb = 0; rs1_ex = 0; rs2_ex = 0;
    settle();
    check("fwd_x0", 64'({hu_rs1, hu_rs2}), 64'({SRC_REG, SRC_REG}));
    tick();

    // Load-use: one stall cycle, then the value comes from WB
    idle();
    mem_read_me = 1; reg_write_me = 1; rd_me = 7; mem_ready = 1; rs2_ex = 7;
    settle();
    check("load_use_stall", 64'({stall_fe, stall_de, stall_ex, stall_me, bubble_me}), 64'b11101);
    tick();
    mem_read_me = 0; reg_write_me = 0; rd_me = 0; reg_write_wb = 1; rd_wb = 7;
    settle();
    check("load_use_fwd_wb", 64'(hu_rs2), 64'(SRC_WB));
    tick();

    // Memory wait states: stall_me high exactly 3 cycles
    idle();
    stall_me_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      mem_read_me = (i < 4); reg_write_me = (i < 4); rd_me = 3; mem_ready = (i >= 3);
      settle();
      if (stall_me) stall_me_cycles++;
      tick();
    end
    check("mem_wait_cycles", 64'(stall_me_cycles), 64'd3);

    // DIV to x9 blocks a DE reader until completion
    idle();
    mc_issue_ex = 1; rd_ex = 9;
    settle(); tick();
    mc_issue_ex = 0; rd_ex = 0; rs1_de = 9;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("div_stall_de", 64'({stall_de, flush_ex, busy_mask[9]}), 64'b111);
      tick();
    end
    mc_done = 1; mc_rd = 9;
    settle(); tick();
    mc_done = 0; mc_rd = 0;
    settle();
    check("div_released", 64'({stall_de, busy_mask[9]}), 64'b00);
    tick();

    // Outstanding limit: third issue stalls; issue+done keeps the count at MC_DEPTH
    idle();
    mc_issue_ex = 1; rd_ex = 10; settle(); tick();
    rd_ex = 11; settle(); tick();
    rd_ex = 12;
    settle();
    check("mc_full_stall", 64'({stall_ex, bubble_me}), 64'b11);
    tick();
    mc_done = 1; mc_rd = 10;
    settle();
    check("mc_issue_done_ok", 64'(stall_ex), 64'd0);
    tick();
    mc_done = 0; rd_ex = 13;
    settle();
    check("mc_cnt_kept", 64'(stall_ex), 64'd1);
    tick();
    mc_issue_ex = 0; rd_ex = 0; mc_done = 1; mc_rd = 11; settle(); tick();
    mc_rd = 12; settle(); tick();
    mc_done = 0; mc_rd = 0;
    settle();
    check("mc_drained", 64'(busy_mask), 64'd0);
    tick();

    // Redirect flush window and its extension
    idle();
    pc_r = 1;
    settle();
    check("flush_first", 64'({flush_de, flush_ex}), 64'b11);
    tick();
    pc_r = 0;
    settle(); check("flush_hold", 64'(flush_de), 64'd1); tick();
    settle(); check("flush_end", 64'(flush_de), 64'd0); tick();
    for (int i = 0; i < 5; i++) begin
      pc_r = fl_seq_pc[i];
      settle();
      check("flush_extend", 64'(flush_de), 64'(fl_seq_exp[i]));
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      randomize_inputs();
      settle();
      tick();
    end
    idle();
    settle(); tick();

    // Asynchronous reset in the middle of a DIV
    while (m_q.size() > 0) begin
      mc_done = 1; mc_rd = RAW'(m_q[0]);
      settle(); tick();
    end
    idle();
    mc_issue_ex = 1; rd_ex = 9;
    settle(); tick();
    idle();
    settle();
    check("pre_rst_busy9", 64'(busy_mask[9]), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy_mask), 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    settle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
